// File: rtl/mux_pkg.sv
// mux_pkg: constants shared by the 4:1 mux slice.
//   N_INPUTS   - number of data lanes
//   SEL_W      - select width, clog2(N_INPUTS)
//   DEF_DATA_W - default lane width
package mux_pkg;
  localparam int unsigned N_INPUTS   = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned DEF_DATA_W = 1;

  typedef logic [SEL_W-1:0] sel_t;
endpackage : mux_pkg

// File: rtl/mux_4x1_sel.sv
// mux_4x1_sel: purely combinational lane select.
//   i : N_INPUTS*DATA_W packed lanes, lane k = i[k*DATA_W +: DATA_W]
//   s : lane select
//   f : selected lane
module mux_4x1_sel
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [N_INPUTS*DATA_W-1:0] i,
  input  sel_t                       s,
  output logic [DATA_W-1:0]          f
);

  // 2-D view of the flat bus so each lane is addressed by index.
  logic [N_INPUTS-1:0][DATA_W-1:0] lanes;
  assign lanes = i;

  // Each select value has its own branch; an X/Z select falls to default
  // and propagates X instead of silently choosing a lane.
  always_comb begin
    f = 'x;
    case (s)
      2'd0:    f = lanes[0];
      2'd1:    f = lanes[1];
      2'd2:    f = lanes[2];
      2'd3:    f = lanes[3];
      default: f = 'x;
    endcase
  end

endmodule : mux_4x1_sel

// File: rtl/mux_4x1.sv
// mux_4x1: 4:1 mux with combinational and registered outputs.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   i         : four DATA_W lanes, lane k = i[k*DATA_W +: DATA_W]
//   s         : lane select 0..3
//   F         : registered selected lane (RESET_VAL after reset)
//   F_comb    : combinational selected lane, unaffected by reset
//   out_valid : F holds a sampled lane rather than RESET_VAL
//   s_q       : select that produced the current F
module mux_4x1
  import mux_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_INPUTS*DATA_W-1:0] i,
  input  sel_t                       s,
  output logic [DATA_W-1:0]          F,
  output logic [DATA_W-1:0]          F_comb,
  output logic                       out_valid,
  output sel_t                       s_q
);

  mux_4x1_sel #(.DATA_W(DATA_W)) u_sel (
    .i (i),
    .s (s),
    .f (F_comb)
  );

  // Reset wins over the load in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      F         <= RESET_VAL;
      s_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      F         <= F_comb;
      s_q       <= s;
      out_valid <= 1'b1;
    end
  end

endmodule : mux_4x1

// File: tb/tb_mux_4x1.sv
// tb_mux_4x1: directed checks of mux_4x1 at DATA_W=1 and DATA_W=8.
module tb_mux_4x1;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i1;
  logic [1:0] s1;
  logic       f1, fc1, v1;
  logic [1:0] sq1;

  logic [31:0] i8;
  logic [1:0]  s8;
  logic [7:0]  f8, fc8;
  logic        v8;
  logic [1:0]  sq8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_4x1 #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .i(i1), .s(s1),
    .F(f1), .F_comb(fc1), .out_valid(v1), .s_q(sq1)
  );

  mux_4x1 #(.DATA_W(8), .RESET_VAL(8'h5A)) dut8 (
    .clk(clk), .rst(rst), .i(i8), .s(s8),
    .F(f8), .F_comb(fc8), .out_valid(v8), .s_q(sq8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] walk [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [7:0] wide_exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    rst = 1'b1; i1 = '0; s1 = '0; i8 = '0; s8 = '0;
    tick(); tick();
    chk("rst_F1",    32'(f1),  32'h0);
    chk("rst_v1",    32'(v1),  32'h0);
    chk("rst_sq1",   32'(sq1), 32'h0);
    chk("rst_F8",    32'(f8),  32'h5A);
    chk("rst_v8",    32'(v8),  32'h0);
    rst = 1'b0;

    // Walking one for every select: only lane s set yields 1.
    for (int sv = 0; sv < 4; sv++) begin
      for (int k = 0; k < 4; k++) begin
        i1 = walk[k];
        s1 = 2'(sv);
        #1;
        chk($sformatf("walk_comb_s%0d_k%0d", sv, k), 32'(fc1), 32'(k == sv));
        tick();
        chk($sformatf("walk_F_s%0d_k%0d", sv, k), 32'(f1), 32'(k == sv));
        chk($sformatf("walk_sq_s%0d_k%0d", sv, k), 32'(sq1), 32'(sv));
        chk($sformatf("walk_v_s%0d_k%0d", sv, k), 32'(v1), 32'h1);
      end
    end

    // Unselected lanes toggling must not disturb the output.
    s1 = 2'd0; i1 = 4'b0000;
    tick();
    i1 = 4'b1110;
    #1;
    chk("unsel_comb", 32'(fc1), 32'h0);
    tick();
    chk("unsel_F", 32'(f1), 32'h0);

    // Reset mid-operation overrides the pending load; F_comb keeps following.
    rst = 1'b1; i1 = 4'b1111; s1 = 2'd2;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst%0d_F", c),    32'(f1),  32'h0);
      chk($sformatf("rst%0d_v", c),    32'(v1),  32'h0);
      chk($sformatf("rst%0d_sq", c),   32'(sq1), 32'h0);
      chk($sformatf("rst%0d_comb", c), 32'(fc1), 32'h1);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_F",  32'(f1),  32'h1);
    chk("post_rst_v",  32'(v1),  32'h1);
    chk("post_rst_sq", 32'(sq1), 32'h2);

    // Simultaneous select and data change.
    i1 = 4'b0101; s1 = 2'd0;
    tick();
    chk("simul_hold_F", 32'(f1), 32'h1);
    i1 = 4'b1010; s1 = 2'd1;
    tick();
    chk("simul_F",  32'(f1),  32'h1);
    chk("simul_sq", 32'(sq1), 32'h1);

    // Wide lanes.
    i8 = 32'h44332211;
    for (int n = 0; n < 4; n++) begin
      s8 = 2'(3 - n);
      #1;
      chk($sformatf("wide_comb_%0d", n), 32'(fc8), 32'(wide_exp[n]));
      tick();
      chk($sformatf("wide_F_%0d", n),  32'(f8),  32'(wide_exp[n]));
      chk($sformatf("wide_sq_%0d", n), 32'(sq8), 32'(3 - n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule : tb_mux_4x1
